uart_sha256_host: RTL and testbench



---
 rtl/uart_sha256_pkg.sv | 30 +++
 rtl/rx_timeout_counter.sv | 36 +++
 rtl/uart_sha256_host.sv | 176 +++++++++++++++++
 tb/tb_uart_sha256_host.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sha256_pkg.sv
// Shared definitions for the UART SHA-256 host: FSM encoding, framing bytes
// and digest geometry.
package uart_sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_OPEN = 3'd1,
        ST_SEND_DATA = 3'd2,
        ST_SEND_TERM = 3'd3,
        ST_TX_WAIT   = 3'd4,
        ST_RECV      = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERROR     = 3'd7
    } state_e;

    localparam logic [7:0] START_BYTE_DEF = 8'h01;
    localparam logic [7:0] TERM_BYTE_DEF  = 8'hFF;
    localparam int         DIGEST_BYTES   = 32;
    localparam int         DIGEST_W       = DIGEST_BYTES * 8;
    localparam logic [4:0] LAST_BYTE_IDX  = 5'(DIGEST_BYTES - 1);

    // Earlier bytes migrate toward the MSB end as new bytes arrive.
    function automatic logic [DIGEST_W-1:0] shift_in_byte(
        input logic [DIGEST_W-1:0] cur,
        input logic [7:0]          b
    );
        return {cur[DIGEST_W-9:0], b};
    endfunction

endpackage

// File: rtl/rx_timeout_counter.sv
// Idle-cycle counter for digest reception; expired stays high once the
// limit is reached until cleared.
module rx_timeout_counter #(
    parameter int LIMIT = 2_000_000,
    parameter int WIDTH = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic             expired_q;

    // Count enabled cycles, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= {WIDTH{1'b0}};
            expired_q <= 1'b0;
        end else if (clear) begin
            count_q   <= {WIDTH{1'b0}};
            expired_q <= 1'b0;
        end else if (enable && !expired_q) begin
            count_q   <= count_q + ONE_W;
            expired_q <= ((count_q + ONE_W) == LIMIT_W);
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/uart_sha256_host.sv
// Frames a message to a UART hash engine (START, data, TERM) and collects the
// 32-byte digest it returns, with timeout and illegal-terminator detection.
module uart_sha256_host
    import uart_sha256_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 2_000_000,
    parameter logic [7:0] START_BYTE     = START_BYTE_DEF,
    parameter logic [7:0] TERM_BYTE      = TERM_BYTE_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     msg_data,
    input  logic           msg_valid,
    input  logic           msg_last,
    output logic           msg_ready,
    output logic [7:0]     tx_data,
    output logic           tx_start,
    input  logic           tx_busy,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    output logic [255:0]   digest,
    output logic           digest_valid,
    output logic           busy,
    output logic           err_timeout,
    output logic           err_term
);

    state_e                state_q;
    state_e                ret_q;
    logic                  seen_busy_q;
    logic [4:0]            byte_cnt_q;
    logic [7:0]            tx_data_q;
    logic                  tx_start_q;
    logic [DIGEST_W-1:0]   digest_q;
    logic                  digest_valid_q;
    logic                  err_timeout_q;
    logic                  err_term_q;

    logic                  term_violation_s;
    logic                  msg_ready_s;
    logic                  tmo_clear_s;
    logic                  tmo_enable_s;
    logic                  tmo_expired_s;

    // Handshake decode: a non-final terminator byte is refused outright.
    always_comb begin
        term_violation_s = 1'b0;
        msg_ready_s      = 1'b0;
        if (state_q == ST_SEND_DATA) begin
            term_violation_s = msg_valid && (msg_data == TERM_BYTE) && !msg_last;
            msg_ready_s      = !tx_busy && !tx_start_q && !term_violation_s;
        end else begin
            term_violation_s = 1'b0;
            msg_ready_s      = 1'b0;
        end
    end

    // Idle timer runs only in RECV and restarts on every received byte.
    always_comb begin
        tmo_clear_s  = (state_q != ST_RECV) || rx_valid;
        tmo_enable_s = (state_q == ST_RECV) && !rx_valid;
    end

    rx_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_rx_timeout_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmo_clear_s),
        .enable  (tmo_enable_s),
        .expired (tmo_expired_s)
    );

    // Transaction FSM with registered strobes and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            ret_q          <= ST_IDLE;
            seen_busy_q    <= 1'b0;
            byte_cnt_q     <= 5'd0;
            tx_data_q      <= 8'h00;
            tx_start_q     <= 1'b0;
            digest_q       <= {DIGEST_W{1'b0}};
            digest_valid_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_term_q     <= 1'b0;
        end else begin
            tx_start_q     <= 1'b0;
            digest_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (msg_valid) begin
                        err_timeout_q <= 1'b0;
                        err_term_q    <= 1'b0;
                        state_q       <= ST_SEND_OPEN;
                    end
                end
                ST_SEND_OPEN: begin
                    if (!tx_busy) begin
                        tx_start_q  <= 1'b1;
                        tx_data_q   <= START_BYTE;
                        ret_q       <= ST_SEND_DATA;
                        seen_busy_q <= 1'b0;
                        state_q     <= ST_TX_WAIT;
                    end
                end
                ST_SEND_DATA: begin
                    if (term_violation_s) begin
                        err_term_q <= 1'b1;
                        state_q    <= ST_ERROR;
                    end else if (msg_valid && msg_ready_s) begin
                        tx_start_q  <= 1'b1;
                        tx_data_q   <= msg_data;
                        ret_q       <= msg_last ? ST_SEND_TERM : ST_SEND_DATA;
                        seen_busy_q <= 1'b0;
                        state_q     <= ST_TX_WAIT;
                    end
                end
                ST_SEND_TERM: begin
                    if (!tx_busy) begin
                        tx_start_q  <= 1'b1;
                        tx_data_q   <= TERM_BYTE;
                        ret_q       <= ST_RECV;
                        seen_busy_q <= 1'b0;
                        state_q     <= ST_TX_WAIT;
                    end
                end
                ST_TX_WAIT: begin
                    // A full busy high-then-low cycle marks the byte as sent.
                    if (tx_busy) begin
                        seen_busy_q <= 1'b1;
                    end else if (seen_busy_q) begin
                        seen_busy_q <= 1'b0;
                        state_q     <= ret_q;
                        if (ret_q == ST_RECV) begin
                            byte_cnt_q <= 5'd0;
                            digest_q   <= {DIGEST_W{1'b0}};
                        end
                    end
                end
                ST_RECV: begin
                    if (rx_valid) begin
                        digest_q   <= shift_in_byte(digest_q, rx_data);
                        byte_cnt_q <= byte_cnt_q + 5'd1;
                        if (byte_cnt_q == LAST_BYTE_IDX) begin
                            digest_valid_q <= 1'b1;
                            state_q        <= ST_DONE;
                        end
                    end else if (tmo_expired_s) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_ERROR;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                ST_ERROR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign msg_ready    = msg_ready_s;
    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;
    assign busy         = (state_q != ST_IDLE);
    assign err_timeout  = err_timeout_q;
    assign err_term     = err_term_q;

endmodule

// File: tb/tb_uart_sha256_host.sv
// Randomized scoreboard bench for uart_sha256_host: a reference model predicts
// the transmitted frame and digest, independent monitors compare them.
module tb_uart_sha256_host;

    localparam int TMO = 100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   msg_data;
    logic         msg_valid;
    logic         msg_last;
    logic         msg_ready;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         tx_busy;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;
    logic         err_timeout;
    logic         err_term;

    always #5 clk = ~clk;

    uart_sha256_host #(
        .TIMEOUT_CYCLES (TMO),
        .START_BYTE     (8'h01),
        .TERM_BYTE      (8'hFF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .msg_data     (msg_data),
        .msg_valid    (msg_valid),
        .msg_last     (msg_last),
        .msg_ready    (msg_ready),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .digest       (digest),
        .digest_valid (digest_valid),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_term     (err_term)
    );

    int           vectors     = 0;
    int           miscompares = 0;
    int           dv_count    = 0;
    bit           tx_pending  = 1'b0;
    logic [7:0]   exp_tx_q[$];
    logic [255:0] exp_dig_q[$];
    logic [7:0]   cur_msg[$];
    logic [255:0] last_digest = 256'h0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input string why);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", nm, why);
    endtask

    // Transmitter model: busy rises 1..5 cycles after a strobe, lasts 1..6 cycles.
    initial begin
        int d;
        int l;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                if (exp_tx_q.size() == 0)
                    fail_now("tx_unexpected", $sformatf("got byte %0h expected no send", tx_data));
                else
                    chk("tx_byte", tx_data, exp_tx_q.pop_front());
                tx_pending = 1'b1;
                d = $urandom_range(1, 5);
                l = $urandom_range(1, 6);
                @(negedge clk);
                chk("tx_start_pulse", tx_start, 1'b0);
                repeat (d - 1) begin
                    @(negedge clk);
                    if (tx_start) fail_now("tx_start_while_sending", "got strobe expected none");
                end
                tx_busy = 1'b1;
                repeat (l) begin
                    @(negedge clk);
                    if (tx_start) fail_now("tx_start_while_busy", "got strobe expected none");
                end
                tx_busy    = 1'b0;
                tx_pending = 1'b0;
            end
        end
    end

    // Digest monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (digest_valid === 1'b1) begin
                dv_count++;
                if (exp_dig_q.size() == 0)
                    fail_now("digest_unexpected", $sformatf("got %0h expected no digest_valid", digest));
                else
                    chk("digest", digest, exp_dig_q.pop_front());
                @(negedge clk);
                chk("digest_valid_pulse", digest_valid, 1'b0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_start"}, tx_start, 1'b0);
        chk({tag, "_tx_data"}, tx_data, 8'h00);
        chk({tag, "_digest"}, digest, 256'h0);
        chk({tag, "_digest_valid"}, digest_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err_timeout"}, err_timeout, 1'b0);
        chk({tag, "_err_term"}, err_term, 1'b0);
        chk({tag, "_msg_ready"}, msg_ready, 1'b0);
    endtask

    // Reference frame: START, bytes up to a non-final TERM (error), then TERM.
    task automatic build_expected(output bit will_err);
        will_err = 1'b0;
        exp_tx_q.push_back(8'h01);
        for (int i = 0; i < cur_msg.size(); i++) begin
            if (cur_msg[i] == 8'hFF && i != cur_msg.size() - 1) begin
                will_err = 1'b1;
                break;
            end
            exp_tx_q.push_back(cur_msg[i]);
        end
        if (!will_err) exp_tx_q.push_back(8'hFF);
    endtask

    task automatic drive_msg(output bit aborted);
        bit accepted;
        int guard;
        aborted = 1'b0;
        for (int i = 0; i < cur_msg.size() && !aborted; i++) begin
            accepted = 1'b0;
            guard    = 0;
            @(negedge clk);
            msg_data  = cur_msg[i];
            msg_last  = (i == cur_msg.size() - 1);
            msg_valid = 1'b1;
            while (!accepted && !aborted && guard < 500) begin
                #1;
                if (busy && err_term) begin
                    aborted = 1'b1;
                end else if (msg_ready) begin
                    @(posedge clk);
                    accepted = 1'b1;
                end else begin
                    @(negedge clk);
                    guard++;
                end
            end
            if (!accepted && !aborted) begin
                fail_now("msg_accept_timeout", $sformatf("byte %0d not accepted, expected acceptance", i));
                aborted = 1'b1;
            end
        end
        if (!aborted) @(negedge clk);
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic wait_tx_drained();
        int g;
        g = 0;
        while ((exp_tx_q.size() != 0 || tx_pending) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) fail_now("tx_drain_timeout", $sformatf("%0d bytes outstanding, expected 0", exp_tx_q.size()));
    endtask

    task automatic run_txn(input int nreply, input int reset_at);
        bit           will_err;
        bit           aborted;
        int           dv0;
        int           g;
        logic [7:0]   rb[32];
        logic [255:0] model;
        build_expected(will_err);
        dv0 = dv_count;
        drive_msg(aborted);
        if (will_err) begin
            chk("err_term_set", err_term, 1'b1);
            @(negedge clk);
            chk("busy_after_term_err", busy, 1'b0);
            wait_tx_drained();
            chk("tx_frame_truncated", exp_tx_q.size(), 0);
            return;
        end
        chk("err_term_clear", err_term, 1'b0);
        wait_tx_drained();
        repeat (2) @(negedge clk);
        model = 256'h0;
        for (int i = 0; i < nreply; i++) begin
            rb[i] = 8'($urandom_range(0, 255));
            model[(nreply - 1 - i) * 8 +: 8] = rb[i];
        end
        if (nreply == 32 && reset_at < 0) exp_dig_q.push_back(model);
        for (int i = 0; i < nreply; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (i == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("mid_reset");
                repeat (3) @(negedge clk);
                chk("no_digest_after_reset", dv_count, dv0);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            rx_data  = rb[i];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
        end
        if (nreply == 32) begin
            g = 0;
            while (dv_count == dv0 && g < 50) begin
                @(negedge clk);
                g++;
            end
            chk("digest_valid_count", dv_count, dv0 + 1);
            last_digest = model;
            repeat (2) @(negedge clk);
            chk("busy_after_done", busy, 1'b0);
            chk("err_timeout_clear", err_timeout, 1'b0);
        end else begin
            repeat (TMO - 5) @(negedge clk);
            chk("err_timeout_early", err_timeout, 1'b0);
            repeat (10) @(negedge clk);
            chk("err_timeout_set", err_timeout, 1'b1);
            chk("no_digest_valid_on_timeout", dv_count, dv0);
            chk("busy_after_timeout", busy, 1'b0);
            chk("partial_digest", digest[247:0], model[247:0]);
        end
    endtask

    task automatic stray_rx();
        @(negedge clk);
        rx_data  = 8'($urandom_range(0, 255));
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_rx_digest", digest, last_digest);
        chk("stray_rx_busy", busy, 1'b0);
    endtask

    initial begin
        int         n;
        logic [7:0] b;
        rst_n     = 1'b0;
        msg_data  = 8'h00;
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        cur_msg = {8'h61, 8'h62, 8'h63};
        run_txn(32, -1);
        stray_rx();

        cur_msg = {8'hFF};
        run_txn(32, -1);
        chk("err_term_ff_last", err_term, 1'b0);

        cur_msg = {8'h10, 8'hFF, 8'h20};
        run_txn(32, -1);

        cur_msg = {8'h61, 8'h62, 8'h63};
        run_txn(31, -1);

        cur_msg = {8'h61, 8'h62, 8'h63};
        run_txn(32, 10);

        cur_msg = {8'h61, 8'h62, 8'h63};
        run_txn(32, -1);

        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, 6);
            cur_msg.delete();
            for (int j = 0; j < n; j++) begin
                b = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
                cur_msg.push_back(b);
            end
            run_txn(32, -1);
            if (k % 2 == 1) stray_rx();
        end

        repeat (10) @(negedge clk);
        chk("tx_queue_empty_end", exp_tx_q.size(), 0);
        chk("digest_queue_empty_end", exp_dig_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
